trace_stack: RTL
================

# trace_stack

Trail (trace) stack that answers the solver controller's `push_trace` / `pop_trace` requests. It stores one `{var, val, type}` record per assignment, where `type` is 0 for a decision and 1 for an implication or flipped decision. It always presents the top record on registered outputs, so the controller can inspect the top and pop on the following cycle during backtracking. It sits between the controller and nothing else; the controller is its only initiator.

## Interface
- `DEPTH`, default `1 << MAX_VARS_BITS`: number of records; at most one live record per variable.
- `VAR_BITS`, default `MAX_VARS_BITS`: width of the variable index.
- `CNT_BITS`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `clear`  in  1  synchronous flush: empties the stack and clears the sticky flags.
- `push`  in  1  write `{var_in, val_in, type_in}` as the new top.
- `pop`  in  1  remove the top record.
- `var_in`  in  VAR_BITS  variable index of the pushed record.
- `val_in`  in  1  assigned value of the pushed record.
- `type_in`  in  1  0 = decision, 1 = implied or flipped.
- `var_out`  out  VAR_BITS  top record variable; 0 when empty.
- `val_out`  out  1  top record value; 0 when empty.
- `type_out`  out  1  top record type; 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  CNT_BITS  current occupancy.
- `overflow`  out  1  sticky; set by a push while full without a pop.
- `underflow`  out  1  sticky; set by a pop while empty without a push.
- `hwm`  out  CNT_BITS  peak occupancy; present only with `TRACE_HWM_EN`.

## Operation
- Storage: array `mem[0..DEPTH-1]` with record k at `mem[k]`, plus a top-copy register that drives `*_out`.
- Per-cycle priority, evaluated on the registered `count`:
  1. `clear`: count←0, top←0, overflow←0, underflow←0, `hwm`←0. `push` and `pop` are ignored that cycle.
  2. `push & pop & !empty`: replace the top. `mem[count-1]`←in, top←in, count unchanged.
  3. `push & pop & empty`: the pop is ignored and the push is performed as in rule 4. No underflow.
  4. `push & !full`: `mem[count]`←in, top←in, count←count+1.
  5. `push & full` (no pop): the record is dropped, overflow←1, nothing else changes.
  6. `pop & count>=2`: count←count-1, top←`mem[count-2]`.
  7. `pop & count==1`: count←0, top←0.
  8. `pop & empty`: underflow←1, nothing else changes.
- Contents of `mem` are never cleared. Only count and top define state.
- Records are never reordered. The stored `type` is returned exactly as pushed.
- Count arithmetic is unsigned in CNT_BITS and never wraps, because rules 5 and 8 block it.

## Timing
- Reset (`reset`=0, asynchronous): count=0, `var_out`=0, `val_out`=0, `type_out`=0, `empty`=1, `full`=0, overflow=0, underflow=0, `hwm`=0. Takes effect immediately, including mid-operation; no partial update survives.
- All outputs are registered. Effects of a cycle-N request are visible at cycle N+1.
- Latency: push at N gives the new top at N+1. Pop at N gives the next-lower record at N+1.
- Throughput: one operation per cycle, back-to-back, including alternating push and pop.
- There is no ready/valid handshake. The initiator must check `full` and `empty`. Violations are recorded in the sticky flags and are never fatal.
- The array read for a pop uses a combinational index on registered `count`. There is no read-after-write hazard, because a write and a lower-index read never target the same address in one cycle.

## Configuration
- `TRACE_HWM_EN` defined: `hwm` port exists. It updates at the same edge as count: `hwm`←max(`hwm`, next count). It resets to 0 on reset or `clear`.
- `TRACE_HWM_EN` undefined: `hwm` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then push (5,1,0), (9,0,1), (3,1,1) on consecutive cycles -> at cycle 4: count=3, top=(3,1,1), `empty`=0. Three pops -> tops (9,0,1), then (5,1,0), then 0 with `empty`=1.
- With DEPTH=4: fill 4 records, then push (7,1,0) -> `full`=1, overflow=1, top and count unchanged. `clear` -> overflow=0, count=0.
- Pop when empty -> underflow=1, count=0. A following push (2,0,0) works normally: count=1, top=(2,0,0).
- Stack holding (5,1,0): push (5,0,1) with pop in the same cycle -> count=1, top=(5,0,1). Push and pop while empty with in=(4,1,0) -> count=1, no underflow.
- Assert `reset`=0 asynchronously mid-burst of pushes -> all outputs at reset values before the next edge. After release, push (1,1,1) -> count=1.
- With `TRACE_HWM_EN`: push 6, pop 4, push 1 -> `hwm`=6, count=3. `clear` -> `hwm`=0.

Source files
------------

// File: rtl/trace_stack.sv
// trace_stack: LIFO trail of {var, val, type} assignment records with a registered top-of-stack view.
// Ports:
//   clock, reset (asynchronous, active-low)
//   clear                      synchronous flush of occupancy, top and sticky flags
//   push, pop                  requests; push with pop on a non-empty stack replaces the top
//   var_in, val_in, type_in    record to push (type 0 = decision, 1 = implied/flipped)
//   var_out, val_out, type_out registered copy of the top record, 0 when empty
//   empty, full, count         occupancy status
//   overflow, underflow        sticky flags for a push while full / a pop while empty
//   hwm                        peak occupancy, present only when TRACE_HWM_EN is defined
module trace_stack #(
    parameter int MAX_VARS_BITS = 4,
    parameter int DEPTH         = 1 << MAX_VARS_BITS,
    parameter int VAR_BITS      = MAX_VARS_BITS,
    parameter int CNT_BITS      = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [VAR_BITS-1:0] var_in,
    input  logic                val_in,
    input  logic                type_in,
    output logic [VAR_BITS-1:0] var_out,
    output logic                val_out,
    output logic                type_out,
    output logic                empty,
    output logic                full,
    output logic [CNT_BITS-1:0] count,
    output logic                overflow,
`ifdef TRACE_HWM_EN
    output logic [CNT_BITS-1:0] hwm,
`endif
    output logic                underflow
);
    localparam int RW = VAR_BITS + 2;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [RW-1:0]       mem_q [DEPTH];
    logic [RW-1:0]       top_q, top_d, rec_in;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                do_rep, do_push, do_pop, do_wr;
    logic [AW-1:0]       wr_idx, rd_idx;
    assign rec_in = {var_in, val_in, type_in};
    assign empty  = count_q == '0;
    assign full   = count_q == CNT_BITS'(DEPTH);
    always_comb begin
        do_rep  = !clear & push & pop & !empty;
        do_push = !clear & push & !full & !do_rep;
        do_pop  = !clear & pop & !push & !empty;
        do_wr   = do_rep | do_push;
        // replace writes the current top slot, a push writes the next free one
        wr_idx  = do_rep ? AW'(count_q - CNT_BITS'(1)) : AW'(count_q);
        // the record below the current top becomes the new top after a pop
        rd_idx  = AW'(count_q - CNT_BITS'(2));
        count_d = clear ? '0 : do_push ? count_q + CNT_BITS'(1) : do_pop ? count_q - CNT_BITS'(1) : count_q;
        top_d   = clear ? '0 : do_wr ? rec_in : do_pop ? (count_q >= CNT_BITS'(2) ? mem_q[rd_idx] : '0) : top_q;
        ovf_d   = !clear & (ovf_q | (push & full & !pop));
        unf_d   = !clear & (unf_q | (pop & empty & !push));
    end
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_idx] <= rec_in;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
`ifdef TRACE_HWM_EN
    logic [CNT_BITS-1:0] hwm_q, hwm_d;
    assign hwm_d = clear ? '0 : count_d > hwm_q ? count_d : hwm_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hwm_q <= '0;
        else hwm_q <= hwm_d;
    end
    assign hwm = hwm_q;
`endif
    assign {var_out, val_out, type_out} = top_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule
